// File: rtl/imm_gen_if.sv
// Handshake and payload bundle between the decode front end and the
// immediate-generation stage.
interface imm_gen_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instr;
    logic            in_valid;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_fmt;
    logic            out_valid;
    logic            illegal;

    modport master (
        output instr, in_valid, stall, flush,
        input  imm, imm_fmt, out_valid, illegal
    );

    modport slave (
        input  instr, in_valid, stall, flush,
        output imm, imm_fmt, out_valid, illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes the RV32 opcode of a valid
// instruction, assembles and sign-extends its immediate, and registers the
// result with stall/flush control. All outputs come straight from flops.
module imm_gen_stage #(
    parameter int XLEN         = 32,
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input logic     clk,
    input logic     rst_n,
    imm_gen_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64, got %0d", XLEN);
    end

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;

    logic [31:0]        instr;
    fmt_e               dec_fmt;
    logic               dec_illegal;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    dec_imm;

    logic [XLEN-1:0]    imm_q;
    fmt_e               fmt_q;
    logic               valid_q;
    logic               illegal_q;

    assign instr = bus.instr;

    // Classify the opcode into an immediate format and flag unknown opcodes.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_OP_IMM, OP_JALR,
            OP_MISC_MEM, OP_SYSTEM:      dec_fmt = FMT_I;
            OP_STORE:                    dec_fmt = FMT_S;
            OP_BRANCH:                   dec_fmt = FMT_B;
            OP_LUI, OP_AUIPC:            dec_fmt = FMT_U;
            OP_JAL:                      dec_fmt = FMT_J;
            OP_OP:                       dec_fmt = FMT_NONE;
            default:                     dec_illegal = 1'b1;
        endcase
    end

    // Assemble the immediate as a 32-bit value (bit 31 is always instr[31]),
    // then sign-extend it to the datapath width.
    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{20{instr[31]}}, instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{12{instr[31]}}, instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec_imm = XLEN'(imm32);
    end

    // Output register: flush beats stall, stall beats load, otherwise idle.
    // Illegal is cleared whenever valid drops so it never reads 1 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: only the pipeline register has a reset here; it is the entire
        // visible state of the stage, so clearing it fully discards the contents.
        if (!rst_n) begin
            imm_q     <= '0;
            fmt_q     <= FMT_NONE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (bus.flush) begin
            // NOTE: state updates use non-blocking assignment so every flop
            // samples the pre-edge values regardless of statement order.
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                valid_q   <= 1'b1;
                illegal_q <= dec_illegal;
                fmt_q     <= dec_fmt;
                if (!dec_illegal || ILLEGAL_ZERO) begin
                    imm_q <= dec_imm;
                end
            end else begin
                valid_q   <= 1'b0;
                illegal_q <= 1'b0;
            end
        end
    end

    assign bus.imm       = imm_q;
    assign bus.imm_fmt   = fmt_q;
    assign bus.out_valid = valid_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances (32-bit zeroing, 32-bit holding,
// 64-bit zeroing) share one stimulus stream and are compared against an
// arithmetic reference model every cycle.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        in_valid, stall, flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_gen_if #(.XLEN(32)) if_a ();
    imm_gen_if #(.XLEN(32)) if_b ();
    imm_gen_if #(.XLEN(64)) if_c ();

    assign if_a.instr = instr;  assign if_a.in_valid = in_valid;
    assign if_a.stall = stall;  assign if_a.flush    = flush;
    assign if_b.instr = instr;  assign if_b.in_valid = in_valid;
    assign if_b.stall = stall;  assign if_b.flush    = flush;
    assign if_c.instr = instr;  assign if_c.in_valid = in_valid;
    assign if_c.stall = stall;  assign if_c.flush    = flush;

    imm_gen_stage #(.XLEN(32), .ILLEGAL_ZERO(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    imm_gen_stage #(.XLEN(32), .ILLEGAL_ZERO(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    imm_gen_stage #(.XLEN(64), .ILLEGAL_ZERO(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    logic [63:0] obs_imm [3];
    logic [2:0]  obs_fmt [3];
    logic        obs_val [3];
    logic        obs_ill [3];

    assign obs_imm[0] = {32'b0, if_a.imm};
    assign obs_imm[1] = {32'b0, if_b.imm};
    assign obs_imm[2] = if_c.imm;
    assign obs_fmt[0] = if_a.imm_fmt;  assign obs_fmt[1] = if_b.imm_fmt;  assign obs_fmt[2] = if_c.imm_fmt;
    assign obs_val[0] = if_a.out_valid; assign obs_val[1] = if_b.out_valid; assign obs_val[2] = if_c.out_valid;
    assign obs_ill[0] = if_a.illegal;  assign obs_ill[1] = if_b.illegal;  assign obs_ill[2] = if_c.illegal;

    // Reference model state per instance.
    int          xlen_of [3] = '{32, 32, 64};
    bit          zero_of [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] e_imm [3];
    logic [2:0]  e_fmt [3];
    logic        e_val [3];
    logic        e_ill [3];

    logic [6:0] legal_ops [11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111,
                                   7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
                                   7'b0010111, 7'b1101111, 7'b0110011};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Immediate value of an instruction as a 64-bit signed number.
    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] fmt,
                                       output logic ill, output logic [63:0] val);
        longint s;
        s   = longint'(signed'(ins));
        ill = 1'b0;
        val = 64'd0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                fmt = 3'd1; val = s >>> 20;
            end
            7'b0100011: begin
                fmt = 3'd2;
                val = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            end
            7'b1100011: begin
                fmt = 3'd3;
                val = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                    | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            end
            7'b0110111, 7'b0010111: begin
                fmt = 3'd4; val = s & 64'hFFFF_FFFF_FFFF_F000;
            end
            7'b1101111: begin
                fmt = 3'd5;
                val = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                    | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            end
            7'b0110011: fmt = 3'd0;
            default: begin fmt = 3'd0; ill = 1'b1; end
        endcase
    endfunction

    function automatic logic [63:0] fit(input int k, input logic [63:0] v);
        return (xlen_of[k] == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            e_imm[k] = 64'd0; e_fmt[k] = 3'd0; e_val[k] = 1'b0; e_ill[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [2:0]  f;
        logic        il;
        logic [63:0] v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ref_decode(instr, f, il, v);
        for (int k = 0; k < 3; k++) begin
            if (flush) begin
                e_val[k] = 1'b0; e_ill[k] = 1'b0;
            end else if (stall) begin
                // everything holds
            end else if (in_valid) begin
                e_val[k] = 1'b1;
                e_ill[k] = il;
                e_fmt[k] = f;
                if (!il)            e_imm[k] = fit(k, v);
                else if (zero_of[k]) e_imm[k] = 64'd0;
            end else begin
                e_val[k] = 1'b0; e_ill[k] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s[%0d].imm", tag, k),       obs_imm[k], e_imm[k]);
            check($sformatf("%s[%0d].fmt", tag, k),       {61'd0, obs_fmt[k]}, {61'd0, e_fmt[k]});
            check($sformatf("%s[%0d].out_valid", tag, k), {63'd0, obs_val[k]}, {63'd0, e_val[k]});
            check($sformatf("%s[%0d].illegal", tag, k),   {63'd0, obs_ill[k]}, {63'd0, e_ill[k]});
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
        instr = i; in_valid = v; stall = s; flush = f;
    endtask

    // One clock: model follows the edge, outputs are sampled 1 ns later,
    // and control returns at the following falling edge for the next drive.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1 check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'hFFF00093, 1'b1, 1'b0, 1'b0);
        model_reset();
        #1 check_all("reset_async");
        cycle("reset_clocked");

        // Release with in_valid low: the release edge must not change outputs.
        drive(32'hFFF00093, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle("release_idle");

        // addi x1,x0,-1
        drive(32'hFFF00093, 1'b1, 1'b0, 1'b0);
        cycle("addi");
        check("addi32_const", obs_imm[0], 64'h0000_0000_FFFF_FFFF);
        check("addi64_const", obs_imm[2], 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_fmt_const", {61'd0, obs_fmt[0]}, 64'd1);

        // Illegal opcode: zeroing instance clears, holding instance keeps -1.
        drive(32'h0000007F, 1'b1, 1'b0, 1'b0);
        cycle("illegal");
        check("illegal_zero_const", obs_imm[0], 64'd0);
        check("illegal_hold_const", obs_imm[1], 64'h0000_0000_FFFF_FFFF);
        check("illegal_flag_const", {63'd0, obs_ill[1]}, 64'd1);

        // Back-to-back sw then beq.
        drive(32'h0020A423, 1'b1, 1'b0, 1'b0);
        cycle("sw");
        check("sw_const", obs_imm[0], 64'h8);
        drive(32'hFE000EE3, 1'b1, 1'b0, 1'b0);
        cycle("beq");
        check("beq_const", obs_imm[0], 64'hFFFF_FFFC);
        check("beq_fmt_const", {61'd0, obs_fmt[0]}, 64'd3);

        drive(32'h123452B7, 1'b1, 1'b0, 1'b0);
        cycle("lui");
        check("lui_const", obs_imm[0], 64'h1234_5000);
        drive(32'h001000EF, 1'b1, 1'b0, 1'b0);
        cycle("jal");
        check("jal_const", obs_imm[0], 64'h800);

        // Load addi, then stall three cycles while new instructions arrive.
        drive(32'hFFF00093, 1'b1, 1'b0, 1'b0);
        cycle("pre_stall");
        for (int n = 0; n < 3; n++) begin
            drive(32'h123452B7 + 32'(n << 12), 1'b1, 1'b1, 1'b0);
            cycle("stall");
            check("stall_hold_const", obs_imm[0], 64'h0000_0000_FFFF_FFFF);
        end

        // Flush together with stall and a valid instruction: dropped.
        drive(32'h001000EF, 1'b1, 1'b1, 1'b1);
        cycle("flush_stall");
        check("flush_valid_const", {63'd0, obs_val[0]}, 64'd0);

        // Idle cycle after a load keeps the payload, drops valid.
        drive(32'h0020A423, 1'b1, 1'b0, 1'b0);
        cycle("pre_idle");
        drive(32'hFE000EE3, 1'b0, 1'b0, 1'b0);
        cycle("idle");

        // Mid-cycle reset pulse while valid: outputs clear before next edge.
        drive(32'hFFF00093, 1'b1, 1'b0, 1'b0);
        cycle("pre_rst");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("midcycle_rst");
        #1 rst_n = 1'b1;
        drive(32'hFFF00093, 1'b0, 1'b0, 1'b0);
        cycle("post_rst_idle");
        drive(32'hFFF00093, 1'b1, 1'b0, 1'b0);
        cycle("post_rst_load");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 99) < 85) r[6:0] = legal_ops[$urandom_range(0, 10)];
            drive(r, ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 8));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width; legal values are 32 and 64; any other value SHALL stop elaboration with an error.
REQ-002 Parameter ILLEGAL_ZERO, default 1, when 1 forces imm to zero for unrecognised opcodes; when 0, imm holds its previous value for them.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 instr  input  32  raw RV32 instruction word, qualified by in_valid.
REQ-006 in_valid  input  1  instr is valid this cycle.
REQ-007 stall  input  1  hold the output register contents.
REQ-008 flush  input  1  discard the stage contents.
REQ-009 imm  output  XLEN  sign-extended immediate, registered.
REQ-010 imm_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 6-7 unused.
REQ-011 out_valid  output  1  imm, imm_fmt and illegal are valid.
REQ-012 illegal  output  1  opcode in instr[6:0] is not recognised; meaningful only while out_valid=1.

Function
REQ-013 Decode SHALL use instr[6:0] only and map opcodes to formats as follows:
  - I: LOAD 0000011, OP_IMM 0010011, JALR 1100111, MISC_MEM 0001111, SYSTEM 1110011.
  - S: STORE 0100011.
  - B: BRANCH 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - NONE, legal: OP 0110011.
  - NONE with illegal=1: every other opcode.
REQ-014 Immediate assembly per format:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-015 Every result, including U, SHALL be sign-extended from instr[31] to XLEN bits; format NONE SHALL yield imm=0.
REQ-016 Latency is exactly one clock: values decoded from instr in cycle N appear on the outputs after the rising edge ending cycle N.
REQ-017 Update priority at each rising edge:
  - flush=1 -> out_valid<=0, payload unchanged, regardless of stall.
  - else stall=1 -> all outputs hold.
  - else in_valid=1 -> load imm, imm_fmt, illegal; out_valid<=1.
  - else -> out_valid<=0, payload unchanged.
REQ-018 When ILLEGAL_ZERO=0 and an illegal opcode is loaded, imm SHALL keep its previous value; imm_fmt<=0 and illegal<=1.
REQ-019 illegal SHALL read 0 whenever out_valid=0.
REQ-020 The outputs SHALL depend on no combinational path from the inputs; all outputs come directly from flops.
REQ-021 Simultaneous flush, stall and in_valid SHALL resolve per REQ-017, and the instruction is dropped.

Reset
REQ-022 While rst_n=0, these outputs SHALL hold immediately, independent of clk:
  - imm=0
  - imm_fmt=0
  - out_valid=0
  - illegal=0
REQ-023 Reset asserted mid-operation SHALL discard the stage contents; the first load after release SHALL occur at the first rising edge with rst_n=1 and in_valid=1.
REQ-024 No output SHALL change on the clock edge coincident with reset release unless in_valid=1 at that edge.

Verification
REQ-025 XLEN=32, instr=0xFFF00093 (addi x1,x0,-1), in_valid=1 -> one cycle later imm=0xFFFFFFFF, imm_fmt=1, out_valid=1, illegal=0.
REQ-026 Back-to-back loads:
  - instr=0x0020A423 (sw x2,8(x1)) -> imm=0x00000008, imm_fmt=2.
  - next instr=0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, imm_fmt=3.
  - Both SHALL appear on consecutive cycles.
REQ-027 U and J formats:
  - instr=0x123452B7 (lui) -> imm=0x12345000, imm_fmt=4.
  - instr=0x001000EF (jal x1,2048) -> imm=0x00000800, imm_fmt=5.
  - With XLEN=64 and instr=0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF.
REQ-028 Stall and flush:
  - Load addi, then stall=1 for 3 cycles with new instr applied -> outputs unchanged for all 3 cycles.
  - flush=1 together with stall=1 -> out_valid=0 next cycle.
REQ-029 Illegal opcode:
  - instr=0x0000007F with ILLEGAL_ZERO=1 -> illegal=1, imm=0, imm_fmt=0.
  - Same instr with ILLEGAL_ZERO=0 -> imm keeps its prior value 0xFFFFFFFF.
REQ-030 Reset and idle cycles:
  - rst_n pulsed low between clock edges while out_valid=1 -> outputs clear immediately, before the next edge.
  - A cycle with in_valid=0 -> out_valid=0, imm unchanged.
